ppu_cpu_regs: RTL
=================

PPU_CPU_REGS -- requirements
Module: ppu_cpu_regs

Interface
REQ-001 SHALL have ports: VGA_CLK in 1, clock; reset in 1, asynchronous, active-high.
REQ-002 SHALL have ports: cpu_cs in 1, access strobe; cpu_we in 1, 1=write; cpu_addr in 3, register select $2000-$2007; cpu_din in 8; cpu_dout out 8; cpu_ready out 1; cpu_rvalid out 1.
REQ-003 SHALL have ports: vblank_start in 1, one-cycle pulse; vblank_end in 1, one-cycle pulse; nmi out 1, active-high level.
REQ-004 SHALL have ports: VRAM_addr out 16; VRAM_WE out 1; VRAM_data_in out 8 (write data); VRAM_data_out in 8 (read data, 1-cycle synchronous latency).
REQ-005 SHALL have ports: palette_addr out 5; palette_WE out 1; palette_data_in out 8; palette_out in 8 (1-cycle latency).
REQ-006 SHALL have ports: oam_addr out 8; oam_WE out 1; oam_data out 8; ctrl out 8; mask out 8; scroll_x out 8; scroll_y out 8.

Function
REQ-007 SHALL accept an access only when cpu_cs=1 and cpu_ready=1; cpu_cs while cpu_ready=0 SHALL be ignored.
REQ-008 SHALL hold a 15-bit temp address t, a 14-bit VRAM address v, a write toggle w, an 8-bit read buffer, and a vblank flag.
REQ-009 Write $2000 SHALL load ctrl; write $2001 SHALL load mask; both visible on outputs next cycle.
REQ-010 Write $2005 with w=0 SHALL load scroll_x and set w; with w=1 SHALL load scroll_y and clear w.
REQ-011 Write $2006 with w=0 SHALL set t[13:8]=din[5:0], clear t[14], set w; with w=1 SHALL set t[7:0]=din, copy v=t[13:0], clear w.
REQ-012 Write $2003 SHALL load oam_addr; write $2004 SHALL pulse oam_WE one cycle with oam_data=din, then increment oam_addr modulo 256.
REQ-013 Write $2007 SHALL pulse VRAM_WE (v[13:8]!=6'h3F, VRAM_addr={2'b00,v}) or palette_WE (v[13:8]==6'h3F) one cycle with data=din, then v += ctrl[2]?32:1 modulo 2^14.
REQ-014 palette_addr SHALL be v[4:0] with bit 4 forced to 0 when v[1:0]==0 (mirrors $3F10/14/18/1C onto $3F00/04/08/0C).
REQ-015 Reads SHALL return data on cpu_dout with cpu_rvalid=1 exactly one cycle after acceptance; cpu_dout SHALL hold until the next read.
REQ-016 Read $2002 SHALL return {vblank_flag, 7'b0}, then clear vblank_flag and w.
REQ-017 Read $2004 SHALL return the OAM shadow byte last written at oam_addr (internal 256x8 array).
REQ-018 Read of $2000/$2001/$2003/$2005/$2006 SHALL return 8'h00 with no side effect.
REQ-019 Read $2007 for a non-palette v SHALL return the read buffer, then refill the buffer from VRAM at the old v and increment v.
REQ-020 Read $2007 for a palette v SHALL return palette_out[5:0] zero-extended and refill the buffer from VRAM at v-14'h1000.
REQ-021 FSM states SHALL be IDLE, RD_ISSUE, RD_CAPTURE: $2007 read moves IDLE->RD_ISSUE (address driven), ->RD_CAPTURE (buffer/dout latched), ->IDLE; cpu_ready=1 only in IDLE.
REQ-022 vblank_start SHALL set vblank_flag; vblank_end SHALL clear it; if both assert in one cycle, clear wins.
REQ-023 A $2002 read accepted in the same cycle as vblank_start SHALL return bit7=0 and suppress setting the flag for that frame.
REQ-024 nmi SHALL equal registered vblank_flag & ctrl[7]; writing ctrl[7]=1 while the flag is set SHALL raise nmi next cycle.
REQ-025 v increment SHALL wrap $3FFF->$0000 at 14 bits.

Reset
REQ-026 reset SHALL asynchronously force: ctrl, mask, scroll_x, scroll_y, oam_addr, t, v, w, buffer, vblank_flag, cpu_dout = 0; all WE pulses, nmi, cpu_rvalid = 0; FSM = IDLE; cpu_ready = 1.
REQ-027 reset mid read SHALL abort the refill and leave the buffer at 0.

Structure
REQ-028 Register-offset constants, FSM state enum, PALETTE_PAGE=6'h3F and increment constants SHALL live in shared package ppu_pkg.
REQ-029 The block SHALL be one module with no sub-module; the OAM shadow SHALL be an inferred array.

Verification
REQ-030 $2006<=$21, $2006<=$08, $2007<=$AB -> VRAM_WE one cycle, VRAM_addr=16'h2108, data $AB; v=$2109.
REQ-031 ctrl[2]=1, v=$3FF0, two $2007 writes -> second write to $0010 (wrap).
REQ-032 v=$3F10, write $2007<=$15 -> palette_WE, palette_addr=5'h00.
REQ-033 VRAM[$2400]=$5A, set v=$2400, two $2007 reads -> first returns stale buffer, second returns $5A; cpu_ready low 2 cycles each.
REQ-034 ctrl=$80, vblank_start pulse -> nmi=1; $2002 read returns $80, nmi drops next cycle, w cleared.
REQ-035 $2002 read coincident with vblank_start -> returns $00, flag stays 0, nmi stays 0.

Source files
------------

// File: rtl/ppu_pkg.sv
// ppu_pkg: shared register offsets, read FSM states and VRAM addressing constants
package ppu_pkg;
  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_MASK    = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_OAMADDR = 3'd3;
  localparam logic [2:0] REG_OAMDATA = 3'd4;
  localparam logic [2:0] REG_SCROLL  = 3'd5;
  localparam logic [2:0] REG_ADDR    = 3'd6;
  localparam logic [2:0] REG_DATA    = 3'd7;
  localparam logic [5:0] PALETTE_PAGE   = 6'h3F;
  localparam logic [13:0] INC_ACROSS    = 14'd1;
  localparam logic [13:0] INC_DOWN      = 14'd32;
  localparam logic [13:0] PAL_MIRROR_OFS = 14'h1000;
  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_CAPTURE} rd_state_e;
  // sprite backdrop entries $3F10/14/18/1C alias the background ones
  function automatic logic [4:0] pal_index(input logic [4:0] a);
    return {a[4] & (a[1:0] != 2'b00), a[3:0]};
  endfunction
endpackage

// File: rtl/ppu_cpu_regs.sv
// ppu_cpu_regs: CPU-facing PPU registers $2000-$2007 with VRAM, palette and OAM access
module ppu_cpu_regs
  import ppu_pkg::*;
(
  input  logic        VGA_CLK,
  input  logic        reset,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ready,
  output logic        cpu_rvalid,
  input  logic        vblank_start,
  input  logic        vblank_end,
  output logic        nmi,
  output logic [15:0] VRAM_addr,
  output logic        VRAM_WE,
  output logic [7:0]  VRAM_data_in,
  input  logic [7:0]  VRAM_data_out,
  output logic [4:0]  palette_addr,
  output logic        palette_WE,
  output logic [7:0]  palette_data_in,
  input  logic [7:0]  palette_out,
  output logic [7:0]  oam_addr,
  output logic        oam_WE,
  output logic [7:0]  oam_data,
  output logic [7:0]  ctrl,
  output logic [7:0]  mask,
  output logic [7:0]  scroll_x,
  output logic [7:0]  scroll_y
);
  rd_state_e state_q, state_d;
  logic [7:0] ctrl_q, ctrl_d, mask_q, mask_d, scroll_x_q, scroll_x_d, scroll_y_q, scroll_y_d;
  logic [7:0] oam_addr_q, oam_addr_d, buf_q, buf_d, dout_q, dout_d;
  logic [14:0] t_q, t_d;
  logic [13:0] v_q, v_d, rd_addr_q, rd_addr_d, v_inc;
  logic w_q, w_d, vblank_q, vblank_d, rvalid_q, rvalid_d, pal_rd_q, pal_rd_d;
  logic acc, wr, rd, v_pal;
  logic [7:0] pal_byte;
  logic [7:0] oam_mem [256];

  assign cpu_ready = state_q == IDLE;
  assign acc = cpu_cs && cpu_ready;
  assign wr = acc && cpu_we;
  assign rd = acc && !cpu_we;
  assign v_pal = v_q[13:8] == PALETTE_PAGE;
  assign v_inc = v_q + (ctrl_q[2] ? INC_DOWN : INC_ACROSS);
  assign pal_byte = palette_out & 8'h3F;

  always_comb begin
    state_d = state_q;
    ctrl_d = ctrl_q;
    mask_d = mask_q;
    scroll_x_d = scroll_x_q;
    scroll_y_d = scroll_y_q;
    oam_addr_d = oam_addr_q;
    buf_d = buf_q;
    dout_d = dout_q;
    t_d = t_q;
    v_d = v_q;
    rd_addr_d = rd_addr_q;
    w_d = w_q;
    rvalid_d = 1'b0;
    pal_rd_d = pal_rd_q;
    // a status read in the vblank_start cycle wins over the set, so the frame's flag is lost
    vblank_d = vblank_end ? 1'b0 : (rd && cpu_addr == REG_STATUS) ? 1'b0 : vblank_start ? 1'b1 : vblank_q;
    if (wr) begin
      case (cpu_addr)
        REG_CTRL:    ctrl_d = cpu_din;
        REG_MASK:    mask_d = cpu_din;
        REG_OAMADDR: oam_addr_d = cpu_din;
        REG_OAMDATA: oam_addr_d = oam_addr_q + 8'd1;
        REG_SCROLL: begin
          scroll_x_d = w_q ? scroll_x_q : cpu_din;
          scroll_y_d = w_q ? cpu_din : scroll_y_q;
          w_d = !w_q;
        end
        REG_ADDR: begin
          t_d = w_q ? {t_q[14:8], cpu_din} : {1'b0, cpu_din[5:0], t_q[7:0]};
          v_d = w_q ? t_d[13:0] : v_q;
          w_d = !w_q;
        end
        REG_DATA:    v_d = v_inc;
        default: ;
      endcase
    end
    if (rd) begin
      rvalid_d = 1'b1;
      dout_d = 8'h00;
      case (cpu_addr)
        REG_STATUS: begin
          dout_d = {vblank_q, 7'b0};
          w_d = 1'b0;
        end
        REG_OAMDATA: dout_d = oam_mem[oam_addr_q];
        REG_DATA: begin
          dout_d = v_pal ? dout_q : buf_q;
          rd_addr_d = v_pal ? v_q - PAL_MIRROR_OFS : v_q;
          pal_rd_d = v_pal;
          v_d = v_inc;
          state_d = RD_ISSUE;
        end
        default: ;
      endcase
    end
    if (state_q == RD_ISSUE) begin
      state_d = RD_CAPTURE;
      dout_d = pal_rd_q ? pal_byte : dout_q;
    end
    if (state_q == RD_CAPTURE) begin
      state_d = IDLE;
      buf_d = VRAM_data_out;
    end
  end

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ctrl_q <= '0;
      mask_q <= '0;
      scroll_x_q <= '0;
      scroll_y_q <= '0;
      oam_addr_q <= '0;
      buf_q <= '0;
      dout_q <= '0;
      t_q <= '0;
      v_q <= '0;
      rd_addr_q <= '0;
      w_q <= 1'b0;
      vblank_q <= 1'b0;
      rvalid_q <= 1'b0;
      pal_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q <= ctrl_d;
      mask_q <= mask_d;
      scroll_x_q <= scroll_x_d;
      scroll_y_q <= scroll_y_d;
      oam_addr_q <= oam_addr_d;
      buf_q <= buf_d;
      dout_q <= dout_d;
      t_q <= t_d;
      v_q <= v_d;
      rd_addr_q <= rd_addr_d;
      w_q <= w_d;
      vblank_q <= vblank_d;
      rvalid_q <= rvalid_d;
      pal_rd_q <= pal_rd_d;
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (oam_WE) oam_mem[oam_addr_q] <= cpu_din;
  end

  // palette data arrives in the cycle after acceptance, so it is passed through while RD_ISSUE
  assign cpu_dout = (state_q == RD_ISSUE && pal_rd_q) ? pal_byte : dout_q;
  assign cpu_rvalid = rvalid_q;
  assign nmi = vblank_q & ctrl_q[7];
  assign VRAM_addr = {2'b00, state_q == RD_ISSUE ? rd_addr_q : v_q};
  assign VRAM_WE = wr && cpu_addr == REG_DATA && !v_pal;
  assign VRAM_data_in = cpu_din;
  assign palette_addr = pal_index(v_q[4:0]);
  assign palette_WE = wr && cpu_addr == REG_DATA && v_pal;
  assign palette_data_in = cpu_din;
  assign oam_addr = oam_addr_q;
  assign oam_WE = wr && cpu_addr == REG_OAMDATA;
  assign oam_data = cpu_din;
  assign ctrl = ctrl_q;
  assign mask = mask_q;
  assign scroll_x = scroll_x_q;
  assign scroll_y = scroll_y_q;
endmodule
